// File: rtl/addr_intlv_pkg.sv
// Shared types and pure permutation functions for the block-interleaver address generator.
// Functions operate on MAX_W-wide vectors with the live width passed as an argument.
package addr_intlv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ROT    = 1'b0;
  localparam logic MODE_BITREV = 1'b1;

  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
    if (w >= MAX_W) return {MAX_W{1'b1}};
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

  // Rotate left within the low w bits; amt must be below w.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] v,
                                            input int unsigned amt,
                                            input int unsigned w);
    logic [2*MAX_W-1:0] dbl;
    logic [2*MAX_W-1:0] wrap;
    dbl  = {{MAX_W{1'b0}}, v & width_mask(w)} << amt;
    wrap = dbl >> w;
    return (dbl[MAX_W-1:0] | wrap[MAX_W-1:0]) & width_mask(w);
  endfunction

  function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] v,
                                            input int unsigned amt,
                                            input int unsigned w);
    return rotl(v, (amt == 0) ? 0 : (w - amt), w);
  endfunction

  // Reverse the low w bits: reverse the whole vector, then drop the empty top.
  function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] v,
                                              input int unsigned w);
    logic [MAX_W-1:0] rev;
    rev = {<<{v}};
    return rev >> (MAX_W - w);
  endfunction

endpackage

// File: rtl/addr_interleaver_gen_permute.sv
// Combinational idx -> addr mapper (addr_permute). With ADDR_INTLV_BITREV_EN defined,
// a mode input selects bit-reverse instead of rotation.
module addr_permute
  import addr_intlv_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int ROT_W  = 3
) (
  input  logic [ADDR_W-1:0] idx,
  input  logic [ROT_W-1:0]  rot,
  input  logic              dir,
`ifdef ADDR_INTLV_BITREV_EN
  input  logic              mode,
`endif
  output logic [ADDR_W-1:0] addr
);

  always_comb begin
    if (dir) addr = ADDR_W'(rotr(MAX_W'(idx), 32'(rot), ADDR_W));
    else     addr = ADDR_W'(rotl(MAX_W'(idx), 32'(rot), ADDR_W));
`ifdef ADDR_INTLV_BITREV_EN
    if (mode == MODE_BITREV) addr = ADDR_W'(bitrev(MAX_W'(idx), ADDR_W));
`endif
  end

endmodule

// File: rtl/addr_interleaver_gen.sv
// Block-interleaver address generator: one permutation of 2^ADDR_W addresses per start,
// registered valid/ready output. Optional bit-reverse mode under ADDR_INTLV_BITREV_EN.
module addr_interleaver_gen
  import addr_intlv_pkg::*;
#(
  parameter int   ADDR_W  = 5,
  parameter int   ROT_W   = (ADDR_W > 1) ? $clog2(ADDR_W) : 1,
  parameter logic DIR_DEF = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ROT_W-1:0]  rot_amt,
  input  logic              dir_sel,
  input  logic              mode_bitrev,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  // Handshake: a beat transfers on a rising edge where out_valid & out_ready;
  // while out_valid & !out_ready every out_* signal holds, only abort may drop out_valid.
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_d, addr_d;
  logic              valid_d, last_d, busy_d, done_d;
  logic [ROT_W-1:0]  rot_q, rot_d;
  logic              dir_q, dir_d;
  logic              hs;

`ifdef ADDR_INTLV_BITREV_EN
  logic mode_q, mode_d;
`else
  logic unused_mode_bitrev;
  assign unused_mode_bitrev = mode_bitrev;
`endif

  assign hs = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = out_idx;
    valid_d = out_valid;
    last_d  = out_last;
    rot_d   = rot_q;
    dir_d   = dir_q;
`ifdef ADDR_INTLV_BITREV_EN
    mode_d  = mode_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
          valid_d = 1'b1;
          last_d  = 1'b0;
          rot_d   = ROT_W'(32'(rot_amt) % 32'(ADDR_W));
          dir_d   = dir_sel ^ DIR_DEF;
`ifdef ADDR_INTLV_BITREV_EN
          mode_d  = mode_bitrev;
`endif
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (hs) begin
          if (out_last) begin
            // Counter stays on the last index; it only restarts on the next start.
            state_d = ST_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            idx_d  = out_idx + 1'b1;
            last_d = (idx_d == LAST_IDX);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Address is mapped from next-idx and next-config so it moves on the same edge as out_idx.
  addr_permute #(
    .ADDR_W (ADDR_W),
    .ROT_W  (ROT_W)
  ) u_permute (
    .idx  (idx_d),
    .rot  (rot_d),
    .dir  (dir_d),
`ifdef ADDR_INTLV_BITREV_EN
    .mode (mode_d),
`endif
    .addr (addr_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      out_idx   <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rot_q     <= '0;
      dir_q     <= 1'b0;
`ifdef ADDR_INTLV_BITREV_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      out_idx   <= idx_d;
      out_addr  <= addr_d;
      out_valid <= valid_d;
      out_last  <= last_d;
      busy      <= busy_d;
      done      <= done_d;
      rot_q     <= rot_d;
      dir_q     <= dir_d;
`ifdef ADDR_INTLV_BITREV_EN
      mode_q    <= mode_d;
`endif
    end
  end

endmodule

// File: tb/tb_addr_interleaver_gen.sv
// Self-checking bench for addr_interleaver_gen (ADDR_W=5) against an arithmetic reference model.
module tb_addr_interleaver_gen;

  localparam int W  = 5;
  localparam int RW = 3;
  localparam int N  = 1 << W;
  localparam bit DIR_DEF = 1'b0;
`ifdef ADDR_INTLV_BITREV_EN
  localparam bit BITREV = 1'b1;
`else
  localparam bit BITREV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [RW-1:0] rot_amt = '0;
  logic          dir_sel = 1'b0;
  logic          mode_bitrev = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, out_valid, out_last;
  logic [W-1:0]  out_addr, out_idx;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Block capture state filled by drive_block
  int beat_idx[$];
  int beat_addr[$];
  bit beat_last[$];
  int beat_cyc[$];
  logic [W-1:0] exp_q[$];
  int start_cyc, done_cyc, done_cnt, hold_viol, stray_valid;
  bit timeout, busy_after_done, abort_valid_after, abort_busy_after;
  bit start_with_abort = 1'b0;

  addr_interleaver_gen #(.ADDR_W(W), .ROT_W(RW), .DIR_DEF(DIR_DEF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .rot_amt(rot_amt),
    .dir_sel(dir_sel), .mode_bitrev(mode_bitrev), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_addr(int idx, int r, bit d, bit m);
    int rr, mask, res;
    rr = r % W;
    mask = N - 1;
    if (m && BITREV) begin
      res = 0;
      for (int b = 0; b < W; b++) if ((idx >> b) & 1) res = res | (1 << (W - 1 - b));
      return res;
    end
    if ((d ^ DIR_DEF) == 1'b0) return ((idx << rr) | (idx >> (W - rr))) & mask;
    return ((idx >> rr) | (idx << (W - rr))) & mask;
  endfunction

  task automatic fill_exp(input int r, input bit d, input bit m);
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back(W'(ref_addr(k, r, d, m)));
  endtask

  // Drives one start, then observes at each negedge; abort_at >= 0 aborts on that idx.
  task automatic drive_block(input int r, input bit d, input bit m, input bit rand_ready,
                             input int abort_at, input bit poke_start);
    bit finished, post_done, aborted, prev_v, prev_r, prev_last, rr;
    logic [W-1:0] prev_addr, prev_idx;
    int n;
    beat_idx.delete(); beat_addr.delete(); beat_last.delete(); beat_cyc.delete();
    done_cyc = -1; done_cnt = 0; hold_viol = 0; stray_valid = 0;
    timeout = 0; busy_after_done = 1; abort_valid_after = 1; abort_busy_after = 1;
    finished = 0; post_done = 0; aborted = 0; prev_v = 0; prev_r = 0;
    prev_addr = '0; prev_idx = '0; prev_last = 0; n = 0;
    @(negedge clk);
    start = 1'b1; abort = start_with_abort; rot_amt = RW'(r); dir_sel = d; mode_bitrev = m;
    out_ready = 1'b1; start_cyc = cyc;
    while (!finished && n < 400) begin
      @(negedge clk);
      n++;
      start = 1'b0; abort = 1'b0;
      rot_amt = RW'($urandom); dir_sel = 1'($urandom); mode_bitrev = 1'($urandom);
      if (prev_v && !prev_r && (out_valid !== 1'b1 || out_addr !== prev_addr ||
          out_idx !== prev_idx || out_last !== prev_last)) hold_viol++;
      if (post_done) begin busy_after_done = busy; finished = 1; end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; post_done = 1; end
      if (aborted) begin abort_valid_after = out_valid; abort_busy_after = busy; finished = 1; end
      rr = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!finished) begin
        if (abort_at >= 0 && out_valid === 1'b1 && int'(out_idx) == abort_at) begin
          abort = 1'b1; rr = 1'b1; aborted = 1;
        end else if (out_valid === 1'b1 && rr) begin
          beat_idx.push_back(int'(out_idx)); beat_addr.push_back(int'(out_addr));
          beat_last.push_back(out_last); beat_cyc.push_back(cyc);
        end
        if (poke_start && busy === 1'b1 && $urandom_range(0, 3) == 0) start = 1'b1;
      end
      out_ready = rr;
      prev_v = out_valid; prev_r = rr; prev_addr = out_addr; prev_idx = out_idx; prev_last = out_last;
    end
    timeout = !finished;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      if (done === 1'b1) done_cnt++;
      if (out_valid === 1'b1) stray_valid++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++;
    if (out_addr !== '0 || out_idx !== '0 || out_last !== 1'b0) begin
      errors++; $display("FAIL reset_data got addr=%0d idx=%0d last=%0b exp=0", out_addr, out_idx, out_last);
    end
    checks++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rot_left;
    drive_block(2, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    fill_exp(2, 1'b0, 1'b0);
    if (timeout) begin errors++; $display("FAIL left_timeout got=1 exp=0"); end
    checks++;
    if (beat_idx.size() != N) begin errors++; $display("FAIL left_count got=%0d exp=%0d", beat_idx.size(), N); end
    checks++;
    for (int k = 0; k < beat_idx.size(); k++) begin
      if (beat_idx[k] != k) begin errors++; $display("FAIL left_idx[%0d] got=%0d exp=%0d", k, beat_idx[k], k); end
      checks++;
      if (W'(beat_addr[k]) !== exp_q[k]) begin
        errors++; $display("FAIL left_addr[%0d] got=%0d exp=%0d", k, beat_addr[k], exp_q[k]);
      end
      checks++;
      if (beat_last[k] != (k == N - 1)) begin errors++; $display("FAIL left_last[%0d] got=%0b", k, beat_last[k]); end
      checks++;
      if (beat_cyc[k] != start_cyc + 1 + k) begin
        errors++; $display("FAIL left_cycle[%0d] got=%0d exp=%0d", k, beat_cyc[k], start_cyc + 1 + k);
      end
      checks++;
    end
    if (beat_addr.size() == N) begin
      if (beat_addr[1] != 4 || beat_addr[8] != 1 || beat_addr[16] != 2 || beat_addr[31] != 31) begin
        errors++; $display("FAIL left_spot got=%0d,%0d,%0d,%0d exp=4,1,2,31",
                           beat_addr[1], beat_addr[8], beat_addr[16], beat_addr[31]);
      end
      checks++;
    end
    if (done_cnt != 1) begin errors++; $display("FAIL left_done_count got=%0d exp=1", done_cnt); end
    checks++;
    if (done_cyc != start_cyc + N + 1) begin
      errors++; $display("FAIL left_done_cycle got=%0d exp=%0d", done_cyc, start_cyc + N + 1);
    end
    checks++;
    if (busy_after_done !== 1'b0) begin errors++; $display("FAIL left_busy_drop got=%0b exp=0", busy_after_done); end
    checks++;
  endtask

  task automatic test_backpressure;
    bit seen[N];
    int dups;
    drive_block(2, 1'b0, 1'b0, 1'b1, -1, 1'b1);
    fill_exp(2, 1'b0, 1'b0);
    dups = 0;
    for (int k = 0; k < N; k++) seen[k] = 0;
    if (timeout) begin errors++; $display("FAIL bp_timeout got=1 exp=0"); end
    checks++;
    if (beat_idx.size() != N) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", beat_idx.size(), N); end
    checks++;
    for (int k = 0; k < beat_idx.size(); k++) begin
      if (beat_idx[k] != k) begin errors++; $display("FAIL bp_idx[%0d] got=%0d exp=%0d", k, beat_idx[k], k); end
      checks++;
      if (W'(beat_addr[k]) !== exp_q[k]) begin
        errors++; $display("FAIL bp_addr[%0d] got=%0d exp=%0d", k, beat_addr[k], exp_q[k]);
      end
      checks++;
      if (seen[beat_addr[k] % N]) dups++;
      seen[beat_addr[k] % N] = 1;
    end
    if (dups != 0) begin errors++; $display("FAIL bp_unique got=%0d dups exp=0", dups); end
    checks++;
    if (hold_viol != 0) begin errors++; $display("FAIL bp_hold got=%0d exp=0", hold_viol); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
    checks++;
    if (stray_valid != 0) begin errors++; $display("FAIL bp_start_ignored got=%0d exp=0", stray_valid); end
    checks++;
  endtask

  task automatic test_rot_mod_right;
    drive_block(7, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    fill_exp(7, 1'b1, 1'b0);
    if (beat_addr.size() != N) begin errors++; $display("FAIL right_count got=%0d exp=%0d", beat_addr.size(), N); end
    checks++;
    for (int k = 0; k < beat_addr.size(); k++) begin
      if (W'(beat_addr[k]) !== exp_q[k]) begin
        errors++; $display("FAIL right_addr[%0d] got=%0d exp=%0d", k, beat_addr[k], exp_q[k]);
      end
      checks++;
    end
    if (beat_addr.size() == N) begin
      if (beat_addr[4] != 1 || beat_addr[1] != 8) begin
        errors++; $display("FAIL right_spot got=%0d,%0d exp=1,8", beat_addr[4], beat_addr[1]);
      end
      checks++;
    end
  endtask

  task automatic test_rot_zero;
    int bad;
    drive_block(0, 1'($urandom), 1'b0, 1'b1, -1, 1'b0);
    bad = 0;
    for (int k = 0; k < beat_addr.size(); k++) if (beat_addr[k] != beat_idx[k] || beat_idx[k] != k) bad++;
    if (beat_addr.size() != N || bad != 0) begin
      errors++; $display("FAIL zero_identity got=%0d beats %0d bad exp=%0d beats 0 bad", beat_addr.size(), bad, N);
    end
    checks++;
  endtask

  task automatic test_random_cfg;
    int r;
    bit d;
    for (int t = 0; t < 3; t++) begin
      r = $urandom_range(0, (1 << RW) - 1);
      d = 1'($urandom);
      drive_block(r, d, 1'b0, 1'b1, -1, 1'b0);
      fill_exp(r, d, 1'b0);
      if (beat_addr.size() != N || done_cnt != 1) begin
        errors++; $display("FAIL rand_block r=%0d d=%0b got=%0d beats %0d done exp=%0d 1", r, d, beat_addr.size(), done_cnt, N);
      end
      checks++;
      for (int k = 0; k < beat_addr.size(); k++) begin
        if (W'(beat_addr[k]) !== exp_q[k]) begin
          errors++; $display("FAIL rand_addr r=%0d d=%0b [%0d] got=%0d exp=%0d", r, d, k, beat_addr[k], exp_q[k]);
        end
        checks++;
      end
    end
  endtask

  task automatic test_abort;
    drive_block(3, 1'b0, 1'b0, 1'b0, 10, 1'b0);
    if (beat_idx.size() != 10) begin errors++; $display("FAIL abort_beats got=%0d exp=10", beat_idx.size()); end
    checks++;
    if (abort_valid_after !== 1'b0) begin errors++; $display("FAIL abort_valid got=%0b exp=0", abort_valid_after); end
    checks++;
    if (abort_busy_after !== 1'b0) begin errors++; $display("FAIL abort_busy got=%0b exp=0", abort_busy_after); end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    checks++;
    start_with_abort = 1'b1;
    drive_block(1, 1'b1, 1'b0, 1'b1, -1, 1'b0);
    start_with_abort = 1'b0;
    fill_exp(1, 1'b1, 1'b0);
    if (beat_idx.size() != N || beat_idx[0] != 0) begin
      errors++; $display("FAIL restart_block got=%0d beats first=%0d exp=%0d first=0", beat_idx.size(), beat_idx[0], N);
    end
    checks++;
    for (int k = 0; k < beat_addr.size(); k++) begin
      if (W'(beat_addr[k]) !== exp_q[k]) begin
        errors++; $display("FAIL restart_addr[%0d] got=%0d exp=%0d", k, beat_addr[k], exp_q[k]);
      end
      checks++;
    end
    if (done_cnt != 1) begin errors++; $display("FAIL restart_done got=%0d exp=1", done_cnt); end
    checks++;
  endtask

  task automatic test_bitrev;
    drive_block(3, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    fill_exp(3, 1'b0, 1'b1);
    if (beat_addr.size() != N) begin errors++; $display("FAIL mode_count got=%0d exp=%0d", beat_addr.size(), N); end
    checks++;
    for (int k = 0; k < beat_addr.size(); k++) begin
      if (W'(beat_addr[k]) !== exp_q[k]) begin
        errors++; $display("FAIL mode_addr[%0d] got=%0d exp=%0d", k, beat_addr[k], exp_q[k]);
      end
      checks++;
    end
    if (BITREV && beat_addr.size() == N) begin
      if (beat_addr[1] != 16 || beat_addr[3] != 24 || beat_addr[6] != 12) begin
        errors++; $display("FAIL bitrev_spot got=%0d,%0d,%0d exp=16,24,12", beat_addr[1], beat_addr[3], beat_addr[6]);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid;
    int dones, valids;
    @(negedge clk);
    start = 1'b1; rot_amt = 3'd2; dir_sel = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl got valid=%0b busy=%0b done=%0b exp=0", out_valid, busy, done);
    end
    checks++;
    if (out_addr !== '0 || out_idx !== '0 || out_last !== 1'b0) begin
      errors++; $display("FAIL rstmid_data got addr=%0d idx=%0d last=%0b exp=0", out_addr, out_idx, out_last);
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0; valids = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (out_valid === 1'b1) valids++;
    end
    if (dones != 0 || valids != 0) begin
      errors++; $display("FAIL rstmid_after got done=%0d valid=%0d exp=0", dones, valids);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_rot_left();
    test_backpressure();
    test_rot_mod_right();
    test_rot_zero();
    test_random_cfg();
    test_abort();
    test_bitrev();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
